// File: rtl/debounce_multi.sv
// N-channel button debouncer: 2-flop sync, press/release debounce, press pulse, optional auto-repeat.
// Latency: level/press rise DEB_CYCLES+2 edges after the sampling edge; pulses are registered, one cycle wide.
// No backpressure: free-running outputs; DEBOUNCE_AUTOREPEAT_EN enables repeat_o (event_o = press|repeat).
module debounce_multi #(
    parameter int CHANNELS      = 4,
    parameter int CNT_W         = 30,
    parameter int DEB_CYCLES    = 650000,
    parameter int REL_CYCLES    = 650000,
    parameter int REPEAT_DELAY  = 5050000,
    parameter int REPEAT_PERIOD = 5050000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] repeat_o,
    output logic [CHANNELS-1:0] event_o
);

    localparam longint CNT_LIMIT = longint'(1) << CNT_W;

    generate
        if (longint'(DEB_CYCLES) >= CNT_LIMIT || longint'(REL_CYCLES) >= CNT_LIMIT ||
            longint'(REPEAT_DELAY) >= CNT_LIMIT || longint'(REPEAT_PERIOD) >= CNT_LIMIT) begin : g_param_chk
            $error("debounce_multi: a cycle-count parameter does not fit in CNT_W bits");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(REL_CYCLES - 1);
`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRESS_DB = 3'd1,
        ST_HELD     = 3'd2,
        ST_REPEAT   = 3'd3,
        ST_REL_DB   = 3'd4
    } state_t;

    logic [CHANNELS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

    always_comb begin
        sync1_d = in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             level_q, level_d, press_q, press_d, rpt_q, rpt_d, evt_q, evt_d;
        logic             s;
`ifdef DEBOUNCE_AUTOREPEAT_EN
        logic             ret_rep_q, ret_rep_d;   // REL_DB bounce returns to REPEAT rather than HELD
`endif

        assign s = sync2_q[c];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                rpt_q     <= 1'b0;
                evt_q     <= 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                ret_rep_q <= 1'b0;
`endif
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                rpt_q     <= rpt_d;
                evt_q     <= evt_d;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                ret_rep_q <= ret_rep_d;
`endif
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q + CNT_ONE;
`ifdef DEBOUNCE_AUTOREPEAT_EN
            ret_rep_d = ret_rep_q;
`endif
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (s) begin
                        state_d = ST_PRESS_DB;
                        cnt_d   = CNT_ONE;
                    end
                end
                ST_PRESS_DB: begin
                    if (!s) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q >= DEB_LAST) begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                    end
                end
                ST_HELD: begin
                    if (!s) begin
                        state_d = ST_REL_DB;
                        cnt_d   = CNT_ONE;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                        ret_rep_d = 1'b0;
                    end else if (cnt_q == DLY_LAST) begin
                        state_d = ST_REPEAT;
                        cnt_d   = '0;
                    end
`else
                    end else begin
                        cnt_d = '0;
                    end
`endif
                end
`ifdef DEBOUNCE_AUTOREPEAT_EN
                ST_REPEAT: begin
                    if (!s) begin
                        state_d   = ST_REL_DB;
                        cnt_d     = CNT_ONE;
                        ret_rep_d = 1'b1;
                    end else if (cnt_q == PER_LAST) begin
                        cnt_d = '0;
                    end
                end
`endif
                ST_REL_DB: begin
                    if (s) begin
`ifdef DEBOUNCE_AUTOREPEAT_EN
                        state_d = ret_rep_q ? ST_REPEAT : ST_HELD;
`else
                        state_d = ST_HELD;
`endif
                        cnt_d   = '0;
                    end else if (cnt_q >= REL_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        always_comb begin
            level_d = !(state_d == ST_IDLE || state_d == ST_PRESS_DB);
            press_d = (state_q == ST_PRESS_DB) && (state_d == ST_HELD);
`ifdef DEBOUNCE_AUTOREPEAT_EN
            rpt_d   = s && ((state_q == ST_HELD && cnt_q == DLY_LAST) ||
                            (state_q == ST_REPEAT && cnt_q == PER_LAST));
`else
            rpt_d   = 1'b0;
`endif
            evt_d   = press_d | rpt_d;
        end

        assign level[c]    = level_q;
        assign press[c]    = press_q;
        assign repeat_o[c] = rpt_q;
        assign event_o[c]  = evt_q;
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: CHANNELS=2, DEB=4, REL=3, REPEAT_DELAY=10, REPEAT_PERIOD=5.
// Edge 0 is the posedge after which in[0] changes; outputs are sampled 1 time unit after each posedge.
module tb_debounce_multi;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] in_b = 2'b00;
    logic [1:0] level, press, repeat_o, event_o;
    logic [7:0] pat;
    int         n_checks = 0;
    int         n_fail = 0;

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    always #5 clk = ~clk;

    debounce_multi #(
        .CHANNELS(2), .CNT_W(8), .DEB_CYCLES(4), .REL_CYCLES(3),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in(in_b),
        .level(level), .press(press), .repeat_o(repeat_o), .event_o(event_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected repeat pulses: first at 'first', then every 5 cycles up to 'last'.
    function automatic int exp_rep(input int n, input int first, input int last);
        return int'(AR && n >= first && n <= last && ((n - first) % 5 == 0));
    endfunction

    task automatic go_idle(input int n);
        in_b = 2'b00;
        for (int i = 0; i < n; i++) tick();
        check("idle_level", int'(level), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rep;
        #1;
        check("rst_level", int'(level), 0);
        check("rst_pulses", int'({press, repeat_o, event_o}), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst", int'({level, press, repeat_o, event_o}), 0);

        // Clean press on channel 0; channel 1 stays idle.
        tick();
        in_b = 2'b01;
        for (int n = 1; n <= 10; n++) begin
            tick();
            check("clean_level", int'(level[0]), int'(n >= 6));
            check("clean_press", int'(press[0]), int'(n == 6));
            check("clean_event", int'(event_o[0]), int'(n == 6));
            check("clean_repeat", int'(repeat_o[0]), 0);
            check("clean_ch1", int'({level[1], press[1], repeat_o[1], event_o[1]}), 0);
        end
        go_idle(8);

        // Bounce 1,1,1,0,1,1,1,1: count restarts after the 0.
        pat = 8'b1111_0111;
        tick();
        in_b[0] = pat[0];
        for (int n = 1; n <= 12; n++) begin
            tick();
            check("bounce_level", int'(level[0]), int'(n >= 10));
            check("bounce_press", int'(press[0]), int'(n == 10));
            in_b[0] = (n < 8) ? pat[n] : 1'b1;
        end
        go_idle(8);

        // Long hold: press at 6, repeats at 16,21,...,41; in drops after edge 40.
        tick();
        in_b[0] = 1'b1;
        for (int n = 1; n <= 46; n++) begin
            tick();
            rep = exp_rep(n, 16, 41);
            check("hold_level", int'(level[0]), int'(n >= 6 && n <= 44));
            check("hold_press", int'(press[0]), int'(n == 6));
            check("hold_repeat", int'(repeat_o[0]), rep);
            check("hold_event", int'(event_o[0]), int'(n == 6) | rep);
            if (n == 40) in_b[0] = 1'b0;
        end
        go_idle(4);

        // Release bounce: 2-cycle low keeps level and restarts repeat timing; 3-cycle low releases.
        tick();
        in_b[0] = 1'b1;
        for (int n = 1; n <= 32; n++) begin
            tick();
            rep = int'(AR && n == 23);
            check("relb_level", int'(level[0]), int'(n >= 6 && n < 29));
            check("relb_press", int'(press[0]), int'(n == 6));
            check("relb_repeat", int'(repeat_o[0]), rep);
            check("relb_event", int'(event_o[0]), int'(n == 6) | rep);
            if (n == 8)  in_b[0] = 1'b0;
            if (n == 10) in_b[0] = 1'b1;
            if (n == 24) in_b[0] = 1'b0;
        end
        go_idle(4);

        // Reset asserted mid-hold, right after a repeat pulse.
        tick();
        in_b[0] = 1'b1;
        for (int n = 1; n <= 16; n++) tick();
        check("mid_level_before", int'(level[0]), 1);
        check("mid_repeat_before", int'(repeat_o[0]), int'(AR));
        rst_n = 1'b0;
        #1;
        check("mid_rst_outputs", int'({level, press, repeat_o, event_o}), 0);
        tick();
        tick();
        check("mid_rst_held", int'({level, press, repeat_o, event_o}), 0);
        rst_n = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            check("rerun_level", int'(level[0]), int'(n >= 6));
            check("rerun_press", int'(press[0]), int'(n == 6));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- N-channel successor to the single-button debouncer, used for the Breakout paddle and menu buttons.
- Per channel: 2-flop synchroniser, press and release debounce, a clean level, a one-cycle press pulse, and optional hold-to-repeat pulses with separate first-delay and period timing.
- Sits between the raw board buttons and the game control logic.
- All channels share one clock domain and one counter width, and run fully independently.

Parameters:
- CHANNELS, 4, number of independent button channels (>=1)
- CNT_W, 30, width of each per-channel counter
- DEB_CYCLES, 650000, consecutive synchronised-high cycles needed to accept a press (>=1)
- REL_CYCLES, 650000, consecutive synchronised-low cycles needed to accept a release (>=1)
- REPEAT_DELAY, 5050000, cycles from accepted press to first repeat pulse (>=1)
- REPEAT_PERIOD, 5050000, cycles between subsequent repeat pulses (>=1)

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in  input  CHANNELS  raw button inputs, active high, asynchronous to clk
- level  output  CHANNELS  debounced button state
- press  output  CHANNELS  one-cycle pulse on accepted press
- repeat  output  CHANNELS  one-cycle pulse per auto-repeat tick
- event  output  CHANNELS  press OR repeat, registered, same cycle as its source

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n, asynchronous, active-low.
- Reset: all synchroniser flops, counters, level, press, repeat and event go to 0; every FSM goes to IDLE.
  - Reset asserted mid-operation clears immediately, with no pulse emitted.
  - After release, a channel whose input is already high must re-debounce from 0.
- Synchroniser: s = in delayed by 2 flops per channel. The FSM sees only s.
- Per-channel FSM and counter cnt:
  - IDLE (level=0): if s=1, go to PRESS_DB with cnt=1; else cnt=0.
  - PRESS_DB (level=0):
    - s=0: go to IDLE, cnt=0. Any glitch restarts the count.
    - s=1 and cnt==DEB_CYCLES-1: go to HELD, cnt=0, level<=1, press<=1 for one cycle.
    - Otherwise: cnt+1.
  - HELD (level=1):
    - s=0: go to REL_DB with cnt=1, and record return target HELD.
    - s=1 and cnt==REPEAT_DELAY-1: go to REPEAT, cnt=0, repeat<=1 for one cycle.
    - Otherwise: cnt+1.
  - REPEAT (level=1):
    - s=0: go to REL_DB with cnt=1, and record return target REPEAT.
    - s=1 and cnt==REPEAT_PERIOD-1: repeat<=1, cnt=0.
    - Otherwise: cnt+1.
  - REL_DB (level=1):
    - s=1: go back to the recorded target with cnt=0, so repeat timing restarts. No press pulse.
    - s=0 and cnt==REL_CYCLES-1: go to IDLE, level<=0, cnt=0.
    - Otherwise: cnt+1.
- Timing:
  - Latency: in stable high from sampling edge k gives level and press asserted after edge k+DEB_CYCLES+2.
  - First repeat comes REPEAT_DELAY cycles after press; then every REPEAT_PERIOD cycles.
- Outputs:
  - press and repeat are never high in the same cycle on one channel.
  - event = press|repeat, registered alongside them.
- Counter: saturation is not needed, since compares bound cnt. Parameters must fit in CNT_W; an elaboration-time check flags values >= 2**CNT_W.
- Simultaneous events across channels are independent; no arbitration.

Optional Feature:
- Macro: DEBOUNCE_AUTOREPEAT_EN.
- Defined: REPEAT state and the REPEAT_DELAY/REPEAT_PERIOD compares are present, as above.
- Undefined:
  - HELD never leaves except via REL_DB, and cnt stays 0 in HELD.
  - The REPEAT state and repeat compares are not synthesised.
  - repeat is tied to 0, and event equals press.
  - Ports are unchanged.

Test Plan (CHANNELS=2, DEB_CYCLES=4, REL_CYCLES=3, REPEAT_DELAY=10, REPEAT_PERIOD=5):
- Clean press: in[0] high from edge 0 -> level[0] and press[0] rise after edge 6; press is 1 cycle wide; in[1] outputs stay 0.
- Bounce: in[0] pattern 1,1,1,0,1,1,1,1 -> no press during the glitch; press only after 4 consecutive synchronised highs following the 0.
- Auto-repeat (macro defined): hold in[0] 40 cycles -> press at cycle 6, repeat at 16, 21, 26, 31, 36, 41; event mirrors both.
- Release bounce: while held, drop in[0] for 2 cycles, then restore -> level stays 1 with no new press, and the repeat counter restarts. A 3-cycle low drops level after REL_CYCLES.
- Reset mid-hold: assert rst_n=0 while in REPEAT -> all outputs 0 immediately. Release reset with in high -> press again after 6 cycles.
- Macro undefined: hold 40 cycles -> single press, repeat always 0, event equals press.
